// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types plus the L2 port scheduler state encoding.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_c_block;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    DONE    = 2'd3
  } l2_sched_state_t;

endpackage

// File: rtl/register.sv
// Generic load-enabled register with async active-low clear.
module register #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (load) data_d = d_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign q_out = data_q;

endmodule

// File: rtl/l2_port_scheduler.sv
// Arbitrates the single L2 port between I-cache and D-cache misses, D first,
// with a bounded number of consecutive D grants while the I-cache waits.
//
// state   | meaning
// IDLE    | no miss in flight; arbitrate incoming requests
// GRANT_I | I-cache read held on the L2 port until l2_resp
// GRANT_D | D-cache read or writeback held on the L2 port until l2_resp
// DONE    | one bubble cycle so the winner can drop its request
module l2_port_scheduler
  import lc3b_types::*;
#(
  parameter int ADDR_W       = 16,
  parameter int BLOCK_W      = 128,
  parameter int STARVE_LIMIT = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_read,
  input  logic [ADDR_W-1:0]  i_addr,
  output logic               i_resp,
  input  logic               d_read,
  input  logic               d_write,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [BLOCK_W-1:0] d_wdata,
  output logic               d_resp,
  output logic [BLOCK_W-1:0] rdata,
  output logic               l2_read,
  output logic               l2_write,
  output logic [ADDR_W-1:0]  l2_addr,
  output logic [BLOCK_W-1:0] l2_wdata,
  input  logic [BLOCK_W-1:0] l2_rdata,
  input  logic               l2_resp,
  output logic               ld_regs
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  l2_sched_state_t state_q, state_d;
  logic [2:0]      starve_cnt_q, starve_cnt_d;
  logic            l2_read_q, l2_read_d;
  logic            l2_write_q, l2_write_d;
  logic            d_req, grant_d, grant_i, grant;

  assign d_req   = d_read | d_write;
  assign grant_d = (state_q == IDLE) && d_req && (!i_read || (starve_cnt_q < LIMIT));
  assign grant_i = (state_q == IDLE) && !grant_d && i_read;
  assign grant   = grant_d | grant_i;

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    l2_read_d    = l2_read_q;
    l2_write_d   = l2_write_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d    = GRANT_D;
          // A combined read+write request is served as the writeback only.
          l2_write_d = d_write;
          l2_read_d  = !d_write;
          if (i_read) starve_cnt_d = (starve_cnt_q == 3'd7) ? starve_cnt_q : starve_cnt_q + 3'd1;
          else        starve_cnt_d = 3'd0;
        end else if (grant_i) begin
          state_d      = GRANT_I;
          l2_read_d    = 1'b1;
          l2_write_d   = 1'b0;
          starve_cnt_d = 3'd0;
        end
      end
      GRANT_I, GRANT_D: begin
        if (l2_resp) begin
          state_d    = DONE;
          l2_read_d  = 1'b0;
          l2_write_d = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      starve_cnt_q <= 3'd0;
      l2_read_q    <= 1'b0;
      l2_write_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      l2_read_q    <= l2_read_d;
      l2_write_q   <= l2_write_d;
    end
  end

  register #(.WIDTH(ADDR_W)) u_addr_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (grant),
    .d_in  (grant_d ? d_addr : i_addr),
    .q_out (l2_addr)
  );

  register #(.WIDTH(BLOCK_W)) u_wdata_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (grant),
    .d_in  (grant_d ? d_wdata : '0),
    .q_out (l2_wdata)
  );

  assign l2_read  = l2_read_q;
  assign l2_write = l2_write_q;
  assign i_resp   = (state_q == GRANT_I) && l2_resp;
  assign d_resp   = (state_q == GRANT_D) && l2_resp;
  assign rdata    = l2_rdata;
  assign ld_regs  = (state_q == DONE) || ((state_q == IDLE) && !(i_read || d_req));

endmodule
